// File: rtl/mem_xbar.sv
// 1-master / NUM_SLV-slave memory interconnect: window decode, base stripping and response routing.
// Optional define BUS_TIMEOUT_EN adds a watchdog that turns a silent slave into an error response.
module mem_xbar #(
  parameter int                    NUM_SLV   = 4,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE  = {NUM_SLV{32'h0}},
  parameter logic [NUM_SLV*32-1:0] SLV_TOP   = {NUM_SLV{32'h0}},
  parameter logic [31:0]           HOST_ADDR = 32'hFFFF_FFFF,
  parameter int                    HOST_SLV  = 0,
  parameter int                    TIMEOUT   = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memory_valid,
  input  logic                  memory_instr,
  input  logic [31:0]           memory_addr,
  input  logic [31:0]           memory_wdata,
  input  logic [3:0]            memory_wstrb,
  output logic [31:0]           memory_rdata,
  output logic                  memory_ready,
  output logic                  memory_error,
  output logic [NUM_SLV-1:0]    slv_valid,
  output logic                  slv_instr,
  output logic [31:0]           slv_addr,
  output logic [31:0]           slv_wdata,
  output logic [3:0]            slv_wstrb,
  input  logic [NUM_SLV*32-1:0] slv_rdata,
  input  logic [NUM_SLV-1:0]    slv_ready
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  state_t        r_state;
  logic [SW-1:0] r_sel;
`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
`endif

  logic          w_hit;
  logic [SW-1:0] w_idx;
  logic [31:0]   w_base;
  logic          w_rsp_ok;
  logic          w_accept;

  // NOTE: every always_comb output gets a default first, otherwise a path that skips
  // the assignment infers a latch. Descending loop lets the lowest matching index win.
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_base = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (memory_addr >= SLV_BASE[32*i +: 32] && memory_addr < SLV_TOP[32*i +: 32]) begin
        w_hit  = 1'b1;
        w_idx  = SW'(i);
        w_base = SLV_BASE[32*i +: 32];
      end
    end
    if (!w_hit && memory_addr == HOST_ADDR) begin
      w_hit  = 1'b1;
      w_idx  = SW'(HOST_SLV);
      w_base = SLV_BASE[32*HOST_SLV +: 32];
    end
  end

  assign w_rsp_ok = (r_state == S_WAIT) && slv_ready[r_sel];
  assign w_accept = memory_valid && (r_state == S_IDLE || w_rsp_ok);

  always_comb begin
    slv_valid = '0;
    if (w_accept && w_hit) slv_valid[w_idx] = 1'b1;
  end

  assign slv_instr = memory_instr;
  assign slv_addr  = memory_addr - w_base;
  assign slv_wdata = memory_wdata;
  assign slv_wstrb = memory_wstrb;

  // Error response comes straight from the registered ERR state; data path is zero unless a slave answers.
  assign memory_ready = w_rsp_ok || (r_state == S_ERR);
  assign memory_error = (r_state == S_ERR);
  assign memory_rdata = w_rsp_ok ? slv_rdata[32*r_sel +: 32] : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
`ifdef BUS_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else if (r_state == S_ERR) begin
      r_state <= S_IDLE;
    end else if (r_state == S_IDLE || w_rsp_ok) begin
      if (!memory_valid) begin
        r_state <= S_IDLE;
      end else if (w_hit) begin
        r_state <= S_WAIT;
        r_sel   <= w_idx;
`ifdef BUS_TIMEOUT_EN
        r_cnt   <= '0;
`endif
      end else begin
        r_state <= S_ERR;
      end
    end else begin
`ifdef BUS_TIMEOUT_EN
      if (r_cnt == CW'(TIMEOUT - 1)) r_state <= S_ERR;
      else                           r_cnt   <= r_cnt + 1'b1;
`else
      r_state <= S_WAIT;
`endif
    end
  end

endmodule

// File: tb/tb_mem_xbar.sv
// Self-checking bench for mem_xbar: decode vector table, hand-written corner sequences,
// and randomized transactions against a window-list reference model.
module tb_mem_xbar;

  localparam logic [31:0] HOST    = 32'h8000_1000;
  localparam int          HSLV    = 2;
  localparam int          TIMEOUT = 16;

  logic         clock, reset;
  logic         memory_valid, memory_instr;
  logic [31:0]  memory_addr, memory_wdata, memory_rdata;
  logic [3:0]   memory_wstrb, slv_wstrb;
  logic         memory_ready, memory_error;
  logic [2:0]   slv_valid, slv_ready;
  logic         slv_instr;
  logic [31:0]  slv_addr, slv_wdata;
  logic [95:0]  slv_rdata;

  logic [31:0] bases [3] = '{32'h0000_0000, 32'h0200_0000, 32'h8000_0000};
  logic [31:0] tops  [3] = '{32'h0001_0000, 32'h0201_0000, 32'h8001_0000};

  int n_tests = 0;
  int n_fail  = 0;

  mem_xbar #(
    .NUM_SLV  (3),
    .SLV_BASE ({32'h8000_0000, 32'h0200_0000, 32'h0000_0000}),
    .SLV_TOP  ({32'h8001_0000, 32'h0201_0000, 32'h0001_0000}),
    .HOST_ADDR(HOST),
    .HOST_SLV (HSLV),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
    .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready), .memory_error(memory_error),
    .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata), .slv_ready(slv_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  exp_valid;
    logic [31:0] exp_addr;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_slv();
    slv_ready = '0;
    slv_rdata = '0;
  endtask

  // Reference decode: first window in the list that contains the address, then the alias.
  function automatic void ref_decode(input logic [31:0] a, output int idx, output logic [31:0] off);
    idx = -1;
    off = a;
    for (int i = 0; i < 3; i++)
      if (idx < 0 && a >= bases[i] && a < tops[i]) begin
        idx = i;
        off = a - bases[i];
      end
    if (idx < 0 && a == HOST) begin
      idx = HSLV;
      off = a - bases[HSLV];
    end
  endfunction

  // Present a request for one cycle and check the forwarded request.
  task automatic send(input string nm, input logic [31:0] a, input logic [3:0] ws,
                      input logic [2:0] ev, input logic [31:0] ea);
    memory_valid = 1'b1;
    memory_addr  = a;
    memory_wstrb = ws;
    memory_wdata = $urandom;
    memory_instr = 1'($urandom_range(0, 1));
    #1;
    check({nm, ".slv_valid"}, 32'(slv_valid), 32'(ev));
    check({nm, ".slv_addr"}, slv_addr, ea);
    check({nm, ".slv_wdata"}, slv_wdata, memory_wdata);
    check({nm, ".slv_wstrb"}, 32'(slv_wstrb), 32'(ws));
    tick();
    memory_valid = 1'b0;
  endtask

  // Slave s answers lat cycles after the request; optionally a wrong slave pulses meanwhile.
  task automatic respond(input string nm, input int s, input logic [31:0] d, input int lat,
                         input bit distract);
    for (int k = 1; k < lat; k++) begin
      if (distract) begin
        int o;
        o = (s + 1 + int'($urandom_range(0, 1))) % 3;
        slv_ready[o] = 1'b1;
        slv_rdata[32*o +: 32] = $urandom;
      end
      #1;
      check({nm, ".wait_ready"}, 32'(memory_ready), 32'h0);
      check({nm, ".wait_rdata"}, memory_rdata, 32'h0);
      tick();
      clear_slv();
    end
    slv_ready[s] = 1'b1;
    slv_rdata[32*s +: 32] = d;
    #1;
    check({nm, ".ready"}, 32'(memory_ready), 32'h1);
    check({nm, ".rdata"}, memory_rdata, d);
    check({nm, ".error"}, 32'(memory_error), 32'h0);
    tick();
    clear_slv();
  endtask

  // Called in the cycle after an unmapped request was accepted.
  task automatic expect_err(input string nm);
    #1;
    check({nm, ".err_ready"}, 32'(memory_ready), 32'h1);
    check({nm, ".err_error"}, 32'(memory_error), 32'h1);
    check({nm, ".err_rdata"}, memory_rdata, 32'h0);
    tick();
  endtask

  vec_t vecs [8];

  initial begin
    reset = 1'b1;
    memory_valid = 1'b0; memory_instr = 1'b0; memory_addr = '0;
    memory_wdata = '0; memory_wstrb = '0;
    clear_slv();

    vecs[0] = '{32'h0200_0010, 3'b010, 32'h0000_0010};
    vecs[1] = '{32'h0000_0000, 3'b001, 32'h0000_0000};
    vecs[2] = '{32'h0000_FFFF, 3'b001, 32'h0000_FFFF};
    vecs[3] = '{32'h0001_0000, 3'b000, 32'h0001_0000};
    vecs[4] = '{32'h4000_0000, 3'b000, 32'h4000_0000};
    vecs[5] = '{32'h8000_1000, 3'b100, 32'h0000_1000};
    vecs[6] = '{32'h8000_FFFC, 3'b100, 32'h0000_FFFC};
    vecs[7] = '{32'h01FF_FFFF, 3'b000, 32'h01FF_FFFF};

    tick(); tick();
    check("reset.ready", 32'(memory_ready), 32'h0);
    check("reset.error", 32'(memory_error), 32'h0);
    check("reset.rdata", memory_rdata, 32'h0);
    reset = 1'b0;
    tick();

    // Decode table.
    foreach (vecs[v]) begin
      int s;
      s = -1;
      for (int j = 0; j < 3; j++) if (vecs[v].exp_valid[j]) s = j;
      send($sformatf("vec%0d", v), vecs[v].addr, 4'h0, vecs[v].exp_valid, vecs[v].exp_addr);
      if (s >= 0) respond($sformatf("vec%0d", v), s, vecs[v].addr ^ 32'hA5A5_A5A5, 1, 1'b0);
      else expect_err($sformatf("vec%0d", v));
    end

    // Slave 1 answers after 3 cycles.
    send("lat3", 32'h0200_0010, 4'h0, 3'b010, 32'h10);
    respond("lat3", 1, 32'hDEAD_BEEF, 3, 1'b0);

    // Foreign ready from slave 2 while slave 0 is outstanding.
    send("foreign", 32'h0000_0040, 4'h0, 3'b001, 32'h40);
    slv_ready[2] = 1'b1; slv_rdata[64 +: 32] = 32'h1234_5678;
    #1;
    check("foreign.ready", 32'(memory_ready), 32'h0);
    check("foreign.rdata", memory_rdata, 32'h0);
    tick(); clear_slv();
    respond("foreign", 0, 32'hCAFE_0000, 2, 1'b0);

    // Host alias write.
    send("host", HOST, 4'hF, 3'b100, 32'h1000);
    respond("host", 2, 32'h0000_0001, 2, 1'b0);

    // Back-to-back: new request in the response cycle.
    send("b2b", 32'h0000_0100, 4'h0, 3'b001, 32'h100);
    slv_ready[0] = 1'b1; slv_rdata[0 +: 32] = 32'h0BAD_F00D;
    memory_valid = 1'b1; memory_addr = 32'h0200_0020;
    #1;
    check("b2b.ready", 32'(memory_ready), 32'h1);
    check("b2b.rdata", memory_rdata, 32'h0BAD_F00D);
    check("b2b.slv_valid", 32'(slv_valid), 32'h2);
    check("b2b.slv_addr", slv_addr, 32'h20);
    tick(); clear_slv(); memory_valid = 1'b0;
    respond("b2b2", 1, 32'h7777_1111, 2, 1'b0);

    // Request during WAIT without ready is dropped.
    send("drop", 32'h8000_0004, 4'h0, 3'b100, 32'h4);
    memory_valid = 1'b1; memory_addr = 32'h0000_0010;
    #1;
    check("drop.slv_valid", 32'(slv_valid), 32'h0);
    tick(); memory_valid = 1'b0;
    respond("drop", 2, 32'h5555_AAAA, 1, 1'b0);

    // Request during ERR is dropped.
    send("errdrop", 32'h4000_0000, 4'h0, 3'b000, 32'h4000_0000);
    memory_valid = 1'b1; memory_addr = 32'h0000_0010;
    #1;
    check("errdrop.slv_valid", 32'(slv_valid), 32'h0);
    check("errdrop.error", 32'(memory_error), 32'h1);
    tick(); memory_valid = 1'b0;
    #1;
    check("errdrop.idle_ready", 32'(memory_ready), 32'h0);
    tick();

    // Silent slave.
    send("silent", 32'h0000_0200, 4'h0, 3'b001, 32'h200);
`ifdef BUS_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      logic e;
      e = (k == TIMEOUT + 1);
      if (k == 20) begin slv_ready[0] = 1'b1; slv_rdata[0 +: 32] = 32'hFFFF_0000; end
      #1;
      check($sformatf("tmo.ready@%0d", k), 32'(memory_ready), 32'(e));
      check($sformatf("tmo.error@%0d", k), 32'(memory_error), 32'(e));
      check($sformatf("tmo.rdata@%0d", k), memory_rdata, 32'h0);
      tick(); clear_slv();
    end
`else
    for (int k = 1; k <= 40; k++) begin
      #1;
      check($sformatf("hold.ready@%0d", k), 32'(memory_ready), 32'h0);
      tick();
    end
    respond("hold", 0, 32'h1357_9BDF, 1, 1'b0);
`endif
    send("after_silent", 32'h0200_0000, 4'h0, 3'b010, 32'h0);
    respond("after_silent", 1, 32'h2468_ACE0, 2, 1'b0);

    // Reset in WAIT while the slave is answering.
    send("rst", 32'h0200_0008, 4'h0, 3'b010, 32'h8);
    slv_ready[1] = 1'b1; slv_rdata[32 +: 32] = 32'h9999_8888;
    #1;
    check("rst.pre_ready", 32'(memory_ready), 32'h1);
    reset = 1'b1;
    #1;
    check("rst.ready", 32'(memory_ready), 32'h0);
    check("rst.rdata", memory_rdata, 32'h0);
    tick(); clear_slv(); reset = 1'b0;
    tick();
    slv_ready[1] = 1'b1; slv_rdata[32 +: 32] = 32'h9999_8888;
    #1;
    check("rst.stale_ready", 32'(memory_ready), 32'h0);
    tick(); clear_slv();
    send("post_rst", 32'h0000_0010, 4'h0, 3'b001, 32'h10);
    respond("post_rst", 0, 32'hABCD_0123, 1, 1'b0);

    // Randomized transactions against the reference decoder.
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a, off;
      int idx, pick;
      pick = int'($urandom_range(0, 9));
      if (pick < 5) begin
        int s;
        s = int'($urandom_range(0, 2));
        a = bases[s] + 32'($urandom_range(0, 16'hFFFF));
      end else if (pick == 5) a = HOST;
      else a = $urandom;
      ref_decode(a, idx, off);
      send($sformatf("rnd%0d", t), a, 4'($urandom), (idx >= 0) ? 3'(1 << idx) : 3'b000, off);
      if (idx >= 0) respond($sformatf("rnd%0d", t), idx, $urandom, int'($urandom_range(1, 5)), 1'b1);
      else expect_err($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
